// File: rtl/ex_div_iter.sv
// rtl/ex_div_iter.sv - iterative signed/unsigned restoring divider returning {remainder, quotient}
// Optional macro EX_DIV_RADIX4_EN: two restoring steps per cycle, WIDTH/2 iterations.
module ex_div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int WW = 2*WIDTH + 1;
`ifdef EX_DIV_RADIX4_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH/2 - 1);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WW-1:0]      r_work;
  logic [WIDTH-1:0]   r_div;
  logic               r_neg_q, r_neg_r;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic               w_start, w_last, w_neg1, w_neg2;
  logic [WIDTH-1:0]   w_abs1, w_abs2, w_quo, w_rem, w_quo_f, w_rem_f;
  logic [WW-1:0]      w_work_step;

  // Upper WIDTH+1 bits hold the partial remainder, lower WIDTH bits collect quotient bits.
  function automatic logic [WW-1:0] div_step(input logic [WW-1:0] w, input logic [WIDTH-1:0] d);
    logic [WW-1:0]    s;
    logic [WIDTH+1:0] diff;
    s    = {w[WW-2:0], 1'b0};
    diff = {1'b0, s[WW-1:WIDTH]} - {2'b00, d};
    if (!diff[WIDTH+1])
      div_step = {diff[WIDTH:0], s[WIDTH-1:1], 1'b1};
    else
      div_step = s;
  endfunction

  assign w_start = start_i && !annul_i;
  assign w_neg1  = signed_div_i && opdata1_i[WIDTH-1];
  assign w_neg2  = signed_div_i && opdata2_i[WIDTH-1];
  assign w_abs1  = w_neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign w_abs2  = w_neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
  assign w_last  = (r_cnt == LAST_CNT);

`ifdef EX_DIV_RADIX4_EN
  assign w_work_step = div_step(div_step(r_work, r_div), r_div);
`else
  assign w_work_step = div_step(r_work, r_div);
`endif

  assign w_quo   = w_work_step[WIDTH-1:0];
  assign w_rem   = w_work_step[2*WIDTH-1:WIDTH];
  assign w_quo_f = r_neg_q ? (~w_quo + 1'b1) : w_quo;
  assign w_rem_f = r_neg_r ? (~w_rem + 1'b1) : w_rem;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FREE:   if (w_start) w_state_nxt = (opdata2_i == '0) ? S_BYZERO : S_ON;
      S_ON: begin
        if (annul_i)     w_state_nxt = S_FREE;
        else if (w_last) w_state_nxt = S_END;
      end
      S_BYZERO: w_state_nxt = annul_i ? S_FREE : S_END;
      S_END:    if (!start_i || annul_i) w_state_nxt = S_FREE;
      default:  w_state_nxt = S_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_work   <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_FREE: begin
          if (w_start) begin
            r_cnt   <= '0;
            r_work  <= {{(WIDTH+1){1'b0}}, w_abs1};
            r_div   <= w_abs2;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
          end
        end
        S_ON: begin
          if (!annul_i) begin
            r_work <= w_work_step;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
              r_result <= {w_rem_f, w_quo_f};
              r_ready  <= 1'b1;
            end
          end
        end
        S_BYZERO: begin
          if (!annul_i) begin
            r_result <= '0;
            r_ready  <= 1'b1;
          end
        end
        S_END: begin
          if (!start_i || annul_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = (r_state == S_ON) || (r_state == S_BYZERO);

endmodule

// File: tb/tb_ex_div_iter.sv
// tb/tb_ex_div_iter.sv - directed vector bench for ex_div_iter (WIDTH=32)
module tb_ex_div_iter;

`ifdef EX_DIV_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, annul_i, signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, busy_o;

  int checks   = 0;
  int failures = 0;

  ex_div_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Start an op, scramble operands after sampling, wait for ready, then release start.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output int bcnt);
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    lat = 0; bcnt = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
      end
      if (busy_o) bcnt++;
    end while (!ready_o && lat < 200);
    res = result_o;
    @(posedge clk); #1;
    check("hold_result", result_o, res);
    check("hold_ready", {63'd0, ready_o}, 64'd1);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check("drop_ready", {63'd0, ready_o}, 64'd0);
    check("drop_result", result_o, 64'd0);
  endtask

  vec_t        vecs[10];
  logic [63:0] res;
  int          lat, bcnt;
  bit          saw_ready;

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'hE},                 LAT};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},   LAT};
    vecs[2] = '{1'b0, 32'hFFFFFFF9,   32'd2,          {32'd1, 32'h7FFFFFFC},          LAT};
    vecs[3] = '{1'b1, 32'd5,          32'd0,          64'd0,                          2};
    vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},          LAT};
    vecs[5] = '{1'b1, 32'd100,        32'hFFFFFFF9,   {32'd2, 32'hFFFFFFF2},          LAT};
    vecs[6] = '{1'b0, 32'd5,          32'd0,          64'd0,                          2};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF},          LAT};
    vecs[8] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},         LAT};
    vecs[9] = '{1'b0, 32'd3,          32'd10,         {32'd3, 32'd0},                 LAT};

    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result_o, 64'd0);
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Start request with annul in FREE must not launch anything.
    @(negedge clk);
    opdata1_i = 32'd10; opdata2_i = 32'd2; start_i = 1'b1; annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul_in_free_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat, bcnt);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].lat - 1));
      check($sformatf("vec%0d_no_x", i), {63'd0, $isunknown(res)}, 64'd0);
    end

    // Annul on the 10th ON cycle of 1000/3, then an immediate 9/3.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    saw_ready = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready_o) saw_ready = 1'b1;
    end
    check("annul_busy_before", {63'd0, busy_o}, 64'd1);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul_busy_after", {63'd0, busy_o}, 64'd0);
    check("annul_ready_after", {63'd0, ready_o}, 64'd0);
    check("annul_result_after", result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready_o && lat < 200);
    check("annul_never_ready", {63'd0, saw_ready}, 64'd0);
    check("after_annul_latency", 64'(lat), 64'(LAT));
    check("after_annul_result", result_o, {32'd0, 32'd3});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset between edges in the middle of a division.
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_busy", {63'd0, busy_o}, 64'd1);
    rst = 1'b0; start_i = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy_o}, 64'd0);
    check("async_rst_ready", {63'd0, ready_o}, 64'd0);
    check("async_rst_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 32'd8, 32'd2, res, lat, bcnt);
    check("post_rst_result", res, {32'd0, 32'd4});
    check("post_rst_latency", 64'(lat), 64'(LAT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
